// File: rtl/alu_nxn_seq.sv
// Parametrised sequential ALU: single-cycle ADD/SUB/logic/NOT plus iterative
// shift-add multiply and restoring divide, sequenced by a start/busy/done handshake.
module alu_nxn_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           cin,
    input  logic [2:0]     op,
    output logic [2*W-1:0] res,
    output logic           busy,
    output logic           done,
    output logic           dz
);

    localparam int CW = $clog2(W + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;

    typedef enum logic {IDLE, CALC} state_t;

    state_t          state_q, state_d;
    logic [2*W:0]    acc_q, acc_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic            is_div_q, is_div_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  res_d;
    logic            done_d, dz_d;

    logic [W:0]      add_sum, sub_diff;
    logic [2*W-1:0]  single_res;
    logic [W:0]      mul_sum;
    logic [2*W:0]    mul_next;
    logic [2*W:0]    div_shift;
    logic [W+1:0]    div_diff;
    logic [2*W:0]    div_next;
    logic [2*W:0]    step_next;

    // Single-cycle results come straight from the live inputs at the accepting edge.
    always_comb begin
        add_sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        sub_diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
        case (op)
            OP_ADD:  single_res = {{(W-1){1'b0}}, add_sum};
            OP_SUB:  single_res = {{(W-1){1'b0}}, sub_diff};
            OP_AND:  single_res = {{W{1'b0}}, a & b};
            OP_OR:   single_res = {{W{1'b0}}, a | b};
            OP_XOR:  single_res = {{W{1'b0}}, a ^ b};
            default: single_res = {{W{1'b0}}, ~a};
        endcase
    end

    // acc holds {partial product, remaining multiplier} for MUL and
    // {partial remainder, dividend/quotient bits} for DIV.
    always_comb begin
        mul_sum   = acc_q[2*W:W] + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
        mul_next  = {1'b0, mul_sum, acc_q[W-1:1]};
        div_shift = {acc_q[2*W-1:0], 1'b0};
        div_diff  = {1'b0, div_shift[2*W:W]} - {2'b00, opnd_q};
        div_next  = div_diff[W+1] ? div_shift
                                  : {div_diff[W:0], div_shift[W-1:1], 1'b1};
        step_next = is_div_q ? div_next : mul_next;
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        res_d    = res;
        dz_d     = dz;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        acc_d    = {{(W+1){1'b0}}, b};
                        opnd_d   = a;
                        is_div_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = CALC;
                    end else if (op == OP_DIV) begin
                        acc_d    = {{(W+1){1'b0}}, a};
                        opnd_d   = b;
                        is_div_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = CALC;
                    end else begin
                        res_d  = single_res;
                        dz_d   = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            CALC: begin
                acc_d = step_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    res_d   = step_next[2*W-1:0];
                    dz_d    = is_div_q && (opnd_q == '0);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            res      <= '0;
            done     <= 1'b0;
            dz       <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            res      <= res_d;
            done     <= done_d;
            dz       <= dz_d;
        end
    end

    assign busy = (state_q == CALC);

endmodule

// File: tb/tb_alu_nxn_seq.sv
// Bench for alu_nxn_seq: drives W=4, 8 and 16 instances in lockstep and checks
// each against an arithmetic reference model.
module tb_alu_nxn_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [2:0]  op;

    logic [7:0]  res4;
    logic [15:0] res8;
    logic [31:0] res16;
    logic        busy4, busy8, busy16;
    logic        done4, done8, done16;
    logic        dz4, dz8, dz16;

    int errors = 0;
    int checks = 0;

    alu_nxn_seq #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a[3:0]), .b(b[3:0]),
        .cin(cin), .op(op), .res(res4), .busy(busy4), .done(done4), .dz(dz4)
    );

    alu_nxn_seq #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a[7:0]), .b(b[7:0]),
        .cin(cin), .op(op), .res(res8), .busy(busy8), .done(done8), .dz(dz8)
    );

    alu_nxn_seq #(.W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .cin(cin), .op(op), .res(res16), .busy(busy16), .done(done16), .dz(dz16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wOf(input int k);
        return 4 << k;
    endfunction

    // Reference result straight from the opcode definitions, in plain integer arithmetic.
    function automatic longint unsigned refRes(input int w, input logic [2:0] o,
                                               input longint unsigned x0,
                                               input longint unsigned y0,
                                               input logic c);
        longint unsigned m, x, y;
        m = (64'd1 << w) - 64'd1;
        x = x0 & m;
        y = y0 & m;
        case (o)
            3'd0: return x + y + longint'(c);
            3'd1: return (x - y - longint'(c)) & ((m << 1) | 64'd1);
            3'd2: return x & y;
            3'd3: return x | y;
            3'd4: return x ^ y;
            3'd5: return x * y;
            3'd6: return (y == 0) ? ((x << w) | m) : (((x % y) << w) | (x / y));
            default: return (~x) & m;
        endcase
    endfunction

    function automatic logic refDz(input int w, input logic [2:0] o, input longint unsigned y0);
        return (o == 3'd6) && ((y0 & ((64'd1 << w) - 64'd1)) == 0);
    endfunction

    task automatic sampleDut(input int k, output logic d, output logic bsy,
                             output logic z, output longint unsigned r);
        case (k)
            0:       begin d = done4;  bsy = busy4;  z = dz4;  r = 64'(res4);  end
            1:       begin d = done8;  bsy = busy8;  z = dz8;  r = 64'(res8);  end
            default: begin d = done16; bsy = busy16; z = dz16; r = 64'(res16); end
        endcase
    endtask

    task automatic checkOutput(input string tag, input longint unsigned obs,
                               input longint unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "/W4"},  64'({res4,  busy4,  done4,  dz4}),  64'd0);
        checkOutput({tag, "/W8"},  64'({res8,  busy8,  done8,  dz8}),  64'd0);
        checkOutput({tag, "/W16"}, 64'({res16, busy16, done16, dz16}), 64'd0);
    endtask

    // Issues one operation, scrambles the inputs after acceptance, optionally pulses
    // a stray ADD start while busy, then checks done count, latency, busy span and result.
    task automatic applyStimulus(input logic [2:0] o, input logic [15:0] aa,
                                 input logic [15:0] bb, input logic c,
                                 input bit glitch, input string tag);
        int dcnt[3];
        int dat[3];
        int bcnt[3];
        longint unsigned rcap[3];
        logic zcap[3];
        logic d, bsy, z;
        longint unsigned r;
        bit multi;
        for (int k = 0; k < 3; k++) begin
            dcnt[k] = 0; dat[k] = 0; bcnt[k] = 0; rcap[k] = 0; zcap[k] = 1'b0;
        end
        multi = (o == 3'd5) || (o == 3'd6);
        @(negedge clk);
        a = aa; b = bb; cin = c; op = o; start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); op = 3'($urandom);
            end
            if (glitch && n == 2) begin
                start = 1'b1;
                op = 3'b000;
            end
            if (n == 3) start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                sampleDut(k, d, bsy, z, r);
                if (d) begin
                    dcnt[k]++; dat[k] = n; rcap[k] = r; zcap[k] = z;
                end
                if (bsy) bcnt[k]++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("%s/W%0d/done count", tag, wOf(k)), 64'(dcnt[k]), 64'd1);
            checkOutput($sformatf("%s/W%0d/latency", tag, wOf(k)), 64'(dat[k]),
                        multi ? 64'(wOf(k) + 1) : 64'd1);
            checkOutput($sformatf("%s/W%0d/busy cycles", tag, wOf(k)), 64'(bcnt[k]),
                        multi ? 64'(wOf(k)) : 64'd0);
            checkOutput($sformatf("%s/W%0d/res", tag, wOf(k)), rcap[k],
                        refRes(wOf(k), o, 64'(aa), 64'(bb), c));
            checkOutput($sformatf("%s/W%0d/dz", tag, wOf(k)), 64'(zcap[k]),
                        64'(refDz(wOf(k), o, 64'(bb))));
        end
    endtask

    // AND, OR, XOR, NOT started on four consecutive edges.
    task automatic applyBackToBack();
        logic [2:0]  ops[4];
        logic [15:0] xa[4];
        logic [15:0] xb[4];
        logic d, bsy, z;
        longint unsigned r;
        ops[0] = 3'd2; ops[1] = 3'd3; ops[2] = 3'd4; ops[3] = 3'd7;
        for (int i = 0; i < 4; i++) begin
            xa[i] = 16'($urandom);
            xb[i] = 16'($urandom);
        end
        @(negedge clk);
        a = xa[0]; b = xb[0]; op = ops[0]; cin = 1'($urandom); start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                sampleDut(k, d, bsy, z, r);
                checkOutput($sformatf("b2b%0d/W%0d/done", i, wOf(k)), 64'(d), 64'd1);
                checkOutput($sformatf("b2b%0d/W%0d/res", i, wOf(k)), r,
                            refRes(wOf(k), ops[i], 64'(xa[i]), 64'(xb[i]), 1'b0));
            end
            if (i < 3) begin
                a = xa[i+1]; b = xb[i+1]; op = ops[i+1]; cin = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b/done drops", 64'({done4, done8, done16}), 64'd0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [15:0] ra, rb;
        int          doneSeen;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; op = '0;
        #12;
        checkIdle("reset held");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkIdle("reset released");

        applyStimulus(3'd0, 16'h00FF, 16'h0001, 1'b1, 1'b0, "add");
        applyStimulus(3'd1, 16'h0005, 16'h0007, 1'b0, 1'b0, "sub");

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkIdle("async reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(3'd5, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, "mul");
        applyStimulus(3'd6, 16'd200, 16'd7, 1'b0, 1'b0, "div");
        applyStimulus(3'd6, 16'h002A, 16'h0000, 1'b0, 1'b0, "div by zero");
        applyStimulus(3'd0, 16'h0003, 16'h0004, 1'b0, 1'b0, "add clears dz");

        @(negedge clk);
        a = 16'h0012; b = 16'h0034; op = 3'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 checkOutput("mid-mul busy", 64'({busy4, busy8, busy16}), 64'd7);
        #1 rst_n = 1'b0;
        #1 checkIdle("reset mid-mul");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        doneSeen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done4 || done8 || done16 || busy4 || busy8 || busy16) doneSeen++;
        end
        checkOutput("no done after reset", 64'(doneSeen), 64'd0);
        applyStimulus(3'd5, 16'h0012, 16'h0034, 1'b0, 1'b0, "mul reissue");

        applyBackToBack();

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            applyStimulus(ro, ra, rb, 1'($urandom),
                          ((ro == 3'd5) || (ro == 3'd6)) ? 1'($urandom) : 1'b0,
                          $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_nxn_seq.md
# alu_nxn_seq

Parametrised sequential ALU, successor to the 8x8 combinational ALU. It adds unsigned multiply and divide to the single-cycle ADD/SUB/logic operations, computed iteratively over W cycles. A start/busy/done handshake lets a controller or testbench sequence operations back-to-back. The result is held registered until the next completion.

## Interface
- W, 8, operand width in bits (W ≥ 2); result width is 2W
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy = 0
- a  in  W  operand A, latched on accepted start
- b  in  W  operand B, latched on accepted start
- cin  in  1  carry-in (ADD) / borrow-in (SUB), latched on accepted start
- op  in  3  operation select, latched on accepted start
- res  out  2W  registered result
- busy  out  1  multi-cycle operation in progress
- done  out  1  one-cycle pulse: res valid and updated
- dz  out  1  divide-by-zero flag, registered with res

## Operation
- Opcodes:
  - 000 ADD: res = zero-extend(a + b + cin); res[W] = carry out.
  - 001 SUB: res[W-1:0] = a − b − cin mod 2^W; res[W] = borrow; upper bits 0.
  - 010 AND, 011 OR, 100 XOR: result in res[W-1:0], upper bits 0.
  - 101 MUL: unsigned a × b, full 2W result; shift-add, one partial product per cycle.
  - 110 DIV: unsigned restoring division, one quotient bit per cycle; res[W-1:0] = quotient, res[2W-1:W] = remainder.
  - 111 NOT: res[W-1:0] = ~a, upper bits 0.
- dz = 1 only for DIV with b = 0. In that case res = {a, all-ones quotient}, the result is produced at the normal DIV latency, and dz is 0 for every other completion.
- FSM states:
  - IDLE: on start, latch operands. Ops 101/110 go to CALC, load the iteration counter with 0, and set busy. All other ops stay in IDLE, write res, and pulse done.
  - CALC: one iteration per cycle. On the W-th iteration, write res/dz, pulse done, clear busy, and return to IDLE.
- Internal datapath: accumulator 2W bits plus an extra bit for the DIV trial subtract; counter width is clog2(W+1).
- start while busy = 1 is ignored. It is neither queued nor does it disturb latched operands.
- Inputs a, b, cin and op may change freely after an accepted start.
- res and dz hold their value between done pulses.

## Timing
- Reset (asynchronous, any time, including mid-CALC):
  - State goes to IDLE; res = 0, busy = 0, done = 0, dz = 0.
  - The in-flight operation is discarded with no done pulse.
- First accepted start after rst_n deasserts: start sampled high on the first rising edge with rst_n = 1.
- Single-cycle ops: start accepted at edge k gives res valid and done = 1 after edge k, for one cycle. busy stays 0.
- MUL/DIV: start accepted at edge k.
  - busy = 1 after edge k.
  - Iterations occur at edges k+1 … k+W.
  - res valid, done = 1 and busy = 0 after edge k+W.
  - Latency is W cycles.
- done is never high for two consecutive cycles from a single operation.
- Back-to-back: start high in the cycle where done = 1 (busy = 0) is accepted at that edge. Single-cycle ops can therefore complete every cycle.
- Simultaneous start and reset: reset wins and start is ignored.

## Test plan
- Reset, W=8: hold rst_n low, then release → res = 0x0000, busy = 0, done = 0, dz = 0. Assert rst_n low mid-cycle → all outputs clear immediately (asynchronous).
- ADD/SUB:
  - a = 0xFF, b = 0x01, cin = 1, op = 000 → done one cycle after start, res = 0x0101.
  - a = 0x05, b = 0x07, cin = 0, op = 001 → res = 0x01FE.
- MUL: a = 0xFF, b = 0xFF, op = 101 → busy high for exactly 8 cycles, then done pulse with res = 0xFE01. A start pulsed with op = 000 during busy is ignored, so res and latency are unchanged.
- DIV: a = 200, b = 7, op = 110 → after 8 cycles res = 0x041C, dz = 0. Then a = 0x2A, b = 0, op = 110 → res = 0x2AFF, dz = 1. The next ADD clears dz.
- Reset mid-operation: start MUL 0x12 × 0x34, drop rst_n after 4 cycles → res = 0, busy = 0, and no done pulse. Re-issue → res = 0x03A8 after 8 cycles.
- Back-to-back and parametrisation:
  - Re-run all scenarios with W = 4 and W = 16 (e.g. W=16, MUL 0xFFFF × 0xFFFF → res = 0xFFFE0001 after 16 cycles).
  - Issue AND, OR, XOR, NOT on consecutive cycles → four consecutive done pulses with correct results.
